zynet_selftest: RTL and testbench

ZYNET_SELFTEST -- requirements
Module: zynet_selftest

---
 rtl/zynet_selftest_if.sv | 63 ++++++
 rtl/zynet_selftest.sv | 239 +++++++++++++++++++++++
 tb/tb_zynet_selftest.sv | 294 +++++++++++++++++++++++++++++
 3 files changed

// File: rtl/zynet_selftest_if.sv
// Bus bundle for the self-test sequencer: sample-memory read port, pixel stream and AXI-lite master.
// master = sequencer side, slave = memory / network / register-file side.
interface zynet_selftest_if #(
  parameter int DATA_WIDTH = 16,
  parameter int MEM_AW     = 20
);
  logic                  mem_rd_en;
  logic [MEM_AW-1:0]     mem_addr;
  logic [DATA_WIDTH-1:0] mem_rdata;

  logic [DATA_WIDTH-1:0] axis_out_data;
  logic                  axis_out_valid;
  logic                  axis_out_ready;

  logic [31:0]           m_axi_awaddr;
  logic                  m_axi_awvalid;
  logic                  m_axi_awready;
  logic [31:0]           m_axi_wdata;
  logic                  m_axi_wvalid;
  logic                  m_axi_wready;
  logic                  m_axi_bvalid;
  logic                  m_axi_bready;
  logic [31:0]           m_axi_araddr;
  logic                  m_axi_arvalid;
  logic                  m_axi_arready;
  logic [31:0]           m_axi_rdata;
  logic                  m_axi_rvalid;
  logic                  m_axi_rready;

  modport master (
    output mem_rd_en, mem_addr,
    input  mem_rdata,
    output axis_out_data, axis_out_valid,
    input  axis_out_ready,
    output m_axi_awaddr, m_axi_awvalid,
    input  m_axi_awready,
    output m_axi_wdata, m_axi_wvalid,
    input  m_axi_wready,
    input  m_axi_bvalid,
    output m_axi_bready,
    output m_axi_araddr, m_axi_arvalid,
    input  m_axi_arready,
    input  m_axi_rdata, m_axi_rvalid,
    output m_axi_rready
  );

  modport slave (
    input  mem_rd_en, mem_addr,
    output mem_rdata,
    input  axis_out_data, axis_out_valid,
    output axis_out_ready,
    input  m_axi_awaddr, m_axi_awvalid,
    output m_axi_awready,
    input  m_axi_wdata, m_axi_wvalid,
    output m_axi_wready,
    output m_axi_bvalid,
    input  m_axi_bready,
    input  m_axi_araddr, m_axi_arvalid,
    output m_axi_arready,
    output m_axi_rdata, m_axi_rvalid,
    input  m_axi_rready
  );
endinterface

// File: rtl/zynet_selftest.sv
// Self-test sequencer: soft-resets the network, streams each stored sample, waits for intr, reads and scores the result.
// Stream reaches one beat/cycle after 2 cycles; a 2-entry skid buffer absorbs axis_out_ready backpressure without loss.
module zynet_selftest #(
  parameter int DATA_WIDTH  = 16,
  parameter int NUM_INPUTS  = 784,
  parameter int MEM_AW      = 20,
  parameter int OUT_ADDR    = 8,
  parameter int SRST_ADDR   = 28,
  parameter int TIMEOUT_CYC = 1048576
) (
  input  logic                  s_axi_aclk,
  input  logic                  s_axi_aresetn,
  input  logic                  start,
  input  logic [15:0]           num_samples,
  input  logic                  intr,
  zynet_selftest_if.master      bus,
  output logic                  busy,
  output logic                  done,
  output logic [15:0]           right_cnt,
  output logic [15:0]           wrong_cnt,
  output logic [15:0]           timeout_cnt,
  output logic [DATA_WIDTH-1:0] last_result
);

  typedef enum logic [3:0] {
    IDLE, SRST_W, SRST_B, LABEL, STREAM, WAIT_INTR, RD_AR, RD_R, CMP, FIN
  } state_t;

  localparam int                IW       = $clog2(NUM_INPUTS + 1);
  localparam logic [MEM_AW-1:0] NI_A     = MEM_AW'(NUM_INPUTS);
  localparam logic [MEM_AW-1:0] STRIDE   = MEM_AW'(NUM_INPUTS + 1);
  localparam logic [IW-1:0]     NI_I     = IW'(NUM_INPUTS);
  localparam logic [IW-1:0]     LAST_IDX = IW'(NUM_INPUTS - 1);
  localparam logic [31:0]       TO_LAST  = 32'(TIMEOUT_CYC - 1);

  state_t                state, state_nxt;
  logic [15:0]           n_lat, cmpl;
  logic [MEM_AW-1:0]     base;
  logic [DATA_WIDTH-1:0] label;
  logic                  aw_done, w_done, lbl_wait;
  logic                  intr_q, pend;
  logic [31:0]           tcnt;
  logic [IW-1:0]         rd_idx, beat_idx;
  logic                  rd_q;
  logic [1:0]            sk_cnt;
  logic [DATA_WIDTH-1:0] sk0, sk1;

  logic       aw_hs, w_hs, pop, issue, sk_vld, timeout_hit, sample_end, last_sample;
  logic [1:0] occ;

  function automatic logic [15:0] sat_inc(input logic [15:0] v);
    return (v == 16'hFFFF) ? v : v + 16'd1;
  endfunction

  assign aw_hs  = (state == SRST_W) && !aw_done && bus.m_axi_awready;
  assign w_hs   = (state == SRST_W) && !w_done && bus.m_axi_wready;
  assign sk_vld = (sk_cnt != 2'd0);
  assign pop    = sk_vld && bus.axis_out_ready;
  // Occupancy one cycle ahead, counting the read already in flight; issue only if its data will fit.
  assign occ    = sk_cnt + {1'b0, rd_q} - {1'b0, pop};
  assign issue  = (state == STREAM) && (rd_idx != NI_I) && (occ < 2'd2);

  assign timeout_hit = (state == WAIT_INTR) && !pend && (tcnt == TO_LAST);
  assign sample_end  = (state == CMP) || timeout_hit;
  assign last_sample = ((cmpl + 16'd1) == n_lat);

  assign bus.axis_out_valid = sk_vld;
  assign bus.axis_out_data  = sk0;
  assign bus.m_axi_awaddr   = 32'(SRST_ADDR);
  assign bus.m_axi_wdata    = 32'd0;
  assign bus.m_axi_araddr   = 32'(OUT_ADDR);

  generate
    if (DATA_WIDTH < 32) begin : g_rdata_trunc
      logic rdata_hi_unused;
      assign rdata_hi_unused = ^bus.m_axi_rdata[31:DATA_WIDTH];
    end
  endgenerate

  always_ff @(posedge s_axi_aclk or negedge s_axi_aresetn) begin
    if (!s_axi_aresetn) state <= IDLE;
    else                state <= state_nxt;
  end

  always_comb begin
    state_nxt         = state;
    bus.mem_rd_en     = 1'b0;
    bus.mem_addr      = base + MEM_AW'(rd_idx);
    bus.m_axi_awvalid = 1'b0;
    bus.m_axi_wvalid  = 1'b0;
    bus.m_axi_bready  = 1'b0;
    bus.m_axi_arvalid = 1'b0;
    bus.m_axi_rready  = 1'b0;
    busy              = (state != IDLE);
    done              = 1'b0;
    case (state)
      IDLE:   if (start) state_nxt = SRST_W;
      SRST_W: begin
        bus.m_axi_awvalid = !aw_done;
        bus.m_axi_wvalid  = !w_done;
        if ((aw_done || aw_hs) && (w_done || w_hs)) state_nxt = SRST_B;
      end
      SRST_B: begin
        bus.m_axi_bready = 1'b1;
        if (bus.m_axi_bvalid) state_nxt = (n_lat == 16'd0) ? FIN : LABEL;
      end
      LABEL: begin
        bus.mem_addr  = base + NI_A;
        bus.mem_rd_en = !lbl_wait;
        if (lbl_wait) state_nxt = STREAM;
      end
      STREAM: begin
        bus.mem_rd_en = issue;
        if (pop && (beat_idx == LAST_IDX)) state_nxt = WAIT_INTR;
      end
      WAIT_INTR: begin
        if (pend)             state_nxt = RD_AR;
        else if (timeout_hit) state_nxt = last_sample ? FIN : LABEL;
      end
      RD_AR: begin
        bus.m_axi_arvalid = 1'b1;
        if (bus.m_axi_arready) state_nxt = RD_R;
      end
      RD_R: begin
        bus.m_axi_rready = 1'b1;
        if (bus.m_axi_rvalid) state_nxt = CMP;
      end
      CMP: state_nxt = last_sample ? FIN : LABEL;
      FIN: begin
        done      = 1'b1;
        state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge s_axi_aclk or negedge s_axi_aresetn) begin
    if (!s_axi_aresetn) begin
      n_lat       <= '0;
      cmpl        <= '0;
      base        <= '0;
      label       <= '0;
      aw_done     <= 1'b0;
      w_done      <= 1'b0;
      lbl_wait    <= 1'b0;
      intr_q      <= 1'b0;
      pend        <= 1'b0;
      tcnt        <= '0;
      rd_idx      <= '0;
      beat_idx    <= '0;
      right_cnt   <= '0;
      wrong_cnt   <= '0;
      timeout_cnt <= '0;
      last_result <= '0;
    end else begin
      intr_q <= intr;
      // An early edge is held until WAIT_INTR consumes it; any exit from WAIT_INTR drops it.
      if (intr && !intr_q && (state != IDLE)) pend <= 1'b1;
      if ((state == WAIT_INTR) && (state_nxt != WAIT_INTR)) pend <= 1'b0;
      tcnt <= (state == WAIT_INTR) ? tcnt + 32'd1 : 32'd0;

      case (state)
        IDLE: if (start) begin
          n_lat       <= num_samples;
          cmpl        <= '0;
          base        <= '0;
          aw_done     <= 1'b0;
          w_done      <= 1'b0;
          right_cnt   <= '0;
          wrong_cnt   <= '0;
          timeout_cnt <= '0;
        end
        SRST_W: begin
          if (aw_hs) aw_done <= 1'b1;
          if (w_hs)  w_done  <= 1'b1;
        end
        LABEL: begin
          lbl_wait <= !lbl_wait;
          if (lbl_wait) begin
            label    <= bus.mem_rdata;
            rd_idx   <= '0;
            beat_idx <= '0;
          end
        end
        STREAM: begin
          if (issue) rd_idx   <= rd_idx + IW'(1);
          if (pop)   beat_idx <= beat_idx + IW'(1);
        end
        WAIT_INTR: if (timeout_hit) begin
          timeout_cnt <= sat_inc(timeout_cnt);
          wrong_cnt   <= sat_inc(wrong_cnt);
        end
        RD_R: if (bus.m_axi_rvalid) last_result <= bus.m_axi_rdata[DATA_WIDTH-1:0];
        CMP: begin
          if (last_result == label) right_cnt <= sat_inc(right_cnt);
          else                      wrong_cnt <= sat_inc(wrong_cnt);
        end
        default: ;
      endcase

      if (sample_end) begin
        base <= base + STRIDE;
        cmpl <= cmpl + 16'd1;
      end
    end
  end

  // Skid buffer: sk0 is the head presented on the stream, sk1 holds the overflow beat.
  always_ff @(posedge s_axi_aclk or negedge s_axi_aresetn) begin
    if (!s_axi_aresetn) begin
      rd_q   <= 1'b0;
      sk_cnt <= 2'd0;
      sk0    <= '0;
      sk1    <= '0;
    end else begin
      rd_q <= issue;
      case ({rd_q, pop})
        2'b10: begin
          if (sk_cnt == 2'd0) sk0 <= bus.mem_rdata;
          else                sk1 <= bus.mem_rdata;
          sk_cnt <= sk_cnt + 2'd1;
        end
        2'b01: begin
          sk0    <= sk1;
          sk_cnt <= sk_cnt - 2'd1;
        end
        2'b11: begin
          if (sk_cnt == 2'd1) sk0 <= bus.mem_rdata;
          else begin
            sk0 <= sk1;
            sk1 <= bus.mem_rdata;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_zynet_selftest.sv
// Directed-sequence bench with randomized data/backpressure, scored against a per-sample reference model.
module tb_zynet_selftest;
  localparam int DW  = 16;
  localparam int NI  = 4;
  localparam int AW  = 8;
  localparam int TO  = 64;
  localparam int STR = NI + 1;

  logic          s_axi_aclk = 1'b0;
  logic          s_axi_aresetn;
  logic          start;
  logic [15:0]   num_samples;
  logic          intr;
  logic          busy, done;
  logic [15:0]   right_cnt, wrong_cnt, timeout_cnt;
  logic [DW-1:0] last_result;

  zynet_selftest_if #(.DATA_WIDTH(DW), .MEM_AW(AW)) bus ();

  zynet_selftest #(
    .DATA_WIDTH(DW), .NUM_INPUTS(NI), .MEM_AW(AW),
    .OUT_ADDR(8), .SRST_ADDR(28), .TIMEOUT_CYC(TO)
  ) dut (
    .s_axi_aclk   (s_axi_aclk),
    .s_axi_aresetn(s_axi_aresetn),
    .start        (start),
    .num_samples  (num_samples),
    .intr         (intr),
    .bus          (bus),
    .busy         (busy),
    .done         (done),
    .right_cnt    (right_cnt),
    .wrong_cnt    (wrong_cnt),
    .timeout_cnt  (timeout_cnt),
    .last_result  (last_result)
  );

  always #5 s_axi_aclk = ~s_axi_aclk;

  int errors = 0;
  int checks = 0;

  // Stimulus tables, written by the directed sequence.
  logic [15:0] mem    [0:255];
  bit          mask   [0:15];
  bit          good   [0:15];
  logic [31:0] rd_tbl [0:15];
  bit          rand_ready = 1'b0;
  int          aw_delay   = 0;
  int          clr_gen    = 0;

  // Observations, written by the environment.
  logic [15:0] rx_q[$];
  int          rx_cyc[$];
  int          cyc = 0;
  int          viol, aw_cnt, w_cnt, b_cnt, ar_cnt, r_cnt, done_cnt, aw_cyc, w_cyc, intr_cnt;
  logic [31:0] aw_addr_seen, w_data_seen, ar_addr_seen;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp)
    else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
    end
  endtask

  // Memory, stream sink, AXI-lite slave and interrupt source.
  initial begin
    int seen_gen;
    bit aw_got, w_got, prev_v, prev_r, prev_awp, ar_hs, r_hs, b_hs, rd_en;
    logic [15:0]   prev_d;
    logic [AW-1:0] rd_addr;
    seen_gen = 0; aw_got = 0; w_got = 0; prev_v = 0; prev_r = 0; prev_awp = 0; prev_d = '0;
    viol = 0; aw_cnt = 0; w_cnt = 0; b_cnt = 0; ar_cnt = 0; r_cnt = 0; done_cnt = 0;
    aw_cyc = 0; w_cyc = 0; intr_cnt = 0;
    aw_addr_seen = '0; w_data_seen = '0; ar_addr_seen = '0;
    intr = 1'b0;
    bus.mem_rdata = '0; bus.axis_out_ready = 1'b0;
    bus.m_axi_awready = 1'b0; bus.m_axi_wready = 1'b0; bus.m_axi_bvalid = 1'b0;
    bus.m_axi_arready = 1'b0; bus.m_axi_rvalid = 1'b0; bus.m_axi_rdata = '0;
    forever begin
      @(negedge s_axi_aclk);
      cyc++;
      if (seen_gen != clr_gen) begin
        seen_gen = clr_gen;
        rx_q.delete(); rx_cyc.delete();
        viol = 0; aw_cnt = 0; w_cnt = 0; b_cnt = 0; ar_cnt = 0; r_cnt = 0; done_cnt = 0;
        intr_cnt = 0; aw_got = 0; w_got = 0; prev_v = 0; prev_r = 0; prev_awp = 0;
        intr = 1'b0; bus.m_axi_bvalid = 1'b0; bus.m_axi_rvalid = 1'b0;
      end
      if (prev_v && !prev_r && (!bus.axis_out_valid || bus.axis_out_data !== prev_d)) viol++;
      prev_v = bus.axis_out_valid; prev_r = bus.axis_out_ready; prev_d = bus.axis_out_data;
      if (bus.axis_out_valid && bus.axis_out_ready) begin
        rx_q.push_back(bus.axis_out_data);
        rx_cyc.push_back(cyc);
      end
      if (prev_awp && !bus.m_axi_awvalid) viol++;
      prev_awp = bus.m_axi_awvalid && !bus.m_axi_awready;
      if (w_got && bus.m_axi_wvalid) viol++;
      if (bus.m_axi_awvalid && bus.m_axi_awready) begin
        aw_cnt++; aw_got = 1; aw_cyc = cyc; aw_addr_seen = bus.m_axi_awaddr;
      end
      if (bus.m_axi_wvalid && bus.m_axi_wready) begin
        w_cnt++; w_got = 1; w_cyc = cyc; w_data_seen = bus.m_axi_wdata;
      end
      b_hs = bus.m_axi_bvalid && bus.m_axi_bready;
      if (b_hs) begin b_cnt++; aw_got = 0; w_got = 0; end
      ar_hs = bus.m_axi_arvalid && bus.m_axi_arready;
      if (ar_hs) begin ar_cnt++; ar_addr_seen = bus.m_axi_araddr; end
      r_hs = bus.m_axi_rvalid && bus.m_axi_rready;
      if (r_hs) r_cnt++;
      if (done) done_cnt++;
      rd_en = bus.mem_rd_en; rd_addr = bus.mem_addr;

      @(posedge s_axi_aclk);
      #1;
      if (rd_en) bus.mem_rdata = mem[rd_addr];
      bus.axis_out_ready = rand_ready ? 1'($urandom_range(0, 1)) : 1'b1;
      bus.m_axi_wready  = 1'b1;
      bus.m_axi_awready = (aw_delay == 0) || (w_got && (cyc + 1 - w_cyc >= aw_delay));
      bus.m_axi_bvalid  = aw_got && w_got;
      bus.m_axi_arready = 1'b1;
      if (r_hs) bus.m_axi_rvalid = 1'b0;
      if (ar_hs) begin
        bus.m_axi_rvalid = 1'b1;
        bus.m_axi_rdata  = rd_tbl[(ar_cnt - 1) % 16];
      end
      if (r_hs) intr = 1'b0;
      if (intr_cnt < 16 && rx_q.size() >= NI * (intr_cnt + 1)) begin
        if (mask[intr_cnt]) intr = 1'b1;
        intr_cnt++;
      end
    end
  end

  task automatic clear_env();
    clr_gen++;
    repeat (2) @(negedge s_axi_aclk);
  endtask

  task automatic start_run(input int n);
    @(posedge s_axi_aclk); #1;
    start = 1'b1; num_samples = 16'(n);
    @(posedge s_axi_aclk); #1;
    start = 1'b0;
  endtask

  task automatic wait_done(input string tag);
    int n;
    bit seen;
    n = 0; seen = 0;
    while (!seen && n < 3000) begin
      @(negedge s_axi_aclk);
      n++;
      seen = done;
    end
    check({tag, "_done_seen"}, 32'(seen), 32'd1);
    @(negedge s_axi_aclk);
    check({tag, "_busy_after"}, 32'(busy), 32'd0);
    check({tag, "_done_1cyc"}, 32'(done), 32'd0);
  endtask

  // Fill memory, run n samples, then score against the per-sample model.
  task automatic run_case(input int n, input bit poke, input string tag);
    int k, er, ew, et, nrd;
    logic [15:0] lbl, r, elast;
    logic [15:0] exp_q[$];
    clear_env();
    for (int a = 0; a < n * STR; a++) mem[a] = 16'($urandom);
    k = 0;
    for (int s = 0; s < n; s++) if (mask[s]) begin
      lbl = mem[s * STR + NI];
      r   = good[s] ? lbl : (lbl ^ 16'h0F0F);
      rd_tbl[k] = {16'($urandom), r};
      k++;
    end
    start_run(n);
    if (poke) begin
      repeat (6) @(posedge s_axi_aclk);
      #1; start = 1'b1; num_samples = 16'd9;
      @(posedge s_axi_aclk); #1; start = 1'b0; num_samples = 16'(n);
    end
    wait_done(tag);

    er = 0; ew = 0; et = 0; nrd = 0; elast = '0;
    for (int s = 0; s < n; s++) begin
      if (!mask[s]) begin
        et++; ew++;
      end else begin
        r = rd_tbl[nrd][15:0];
        nrd++;
        if (r == mem[s * STR + NI]) er++; else ew++;
        elast = r;
      end
      for (int i = 0; i < NI; i++) exp_q.push_back(mem[s * STR + i]);
    end

    check({tag, "_right"},   32'(right_cnt),   32'(er));
    check({tag, "_wrong"},   32'(wrong_cnt),   32'(ew));
    check({tag, "_timeout"}, 32'(timeout_cnt), 32'(et));
    if (nrd > 0) begin
      check({tag, "_last_result"}, 32'(last_result), 32'(elast));
      check({tag, "_araddr"}, ar_addr_seen, 32'd8);
    end
    check({tag, "_reads"},   32'(ar_cnt), 32'(nrd));
    check({tag, "_aw_cnt"},  32'(aw_cnt), 32'd1);
    check({tag, "_w_cnt"},   32'(w_cnt),  32'd1);
    check({tag, "_b_cnt"},   32'(b_cnt),  32'd1);
    check({tag, "_awaddr"},  aw_addr_seen, 32'd28);
    check({tag, "_wdata"},   w_data_seen,  32'd0);
    check({tag, "_done_cnt"}, 32'(done_cnt), 32'd1);
    check({tag, "_viol"},    32'(viol), 32'd0);
    check({tag, "_beats"},   32'(rx_q.size()), 32'(exp_q.size()));
    for (int j = 0; j < exp_q.size() && j < rx_q.size(); j++)
      check($sformatf("%s_pix%0d", tag, j), 32'(rx_q[j]), 32'(exp_q[j]));
  endtask

  initial begin
    bit seen;
    s_axi_aresetn = 1'b0; start = 1'b0; num_samples = '0;
    for (int s = 0; s < 16; s++) begin mask[s] = 1'b1; good[s] = 1'b1; end

    repeat (3) @(negedge s_axi_aclk);
    check("rst_busy",     32'(busy), 32'd0);
    check("rst_done",     32'(done), 32'd0);
    check("rst_right",    32'(right_cnt), 32'd0);
    check("rst_wrong",    32'(wrong_cnt), 32'd0);
    check("rst_timeout",  32'(timeout_cnt), 32'd0);
    check("rst_last",     32'(last_result), 32'd0);
    check("rst_tvalid",   32'(bus.axis_out_valid), 32'd0);
    check("rst_awvalid",  32'(bus.m_axi_awvalid), 32'd0);
    check("rst_wvalid",   32'(bus.m_axi_wvalid), 32'd0);
    check("rst_arvalid",  32'(bus.m_axi_arvalid), 32'd0);
    check("rst_rd_en",    32'(bus.mem_rd_en), 32'd0);
    check("rst_readies",  32'({bus.m_axi_bready, bus.m_axi_rready}), 32'd0);
    @(posedge s_axi_aclk); #1;
    s_axi_aresetn = 1'b1;

    // Zero samples: soft-reset write only.
    run_case(0, 1'b0, "zero");

    // Two samples, full-rate stream, correct answers, stray start while busy.
    run_case(2, 1'b1, "two");
    for (int s = 0; s < 2; s++)
      for (int i = 1; i < NI; i++)
        check($sformatf("two_gap_s%0d_b%0d", s, i),
              32'(rx_cyc[s * NI + i] - rx_cyc[s * NI + i - 1]), 32'd1);

    // Random backpressure and a random mix of right and wrong answers.
    rand_ready = 1'b1;
    for (int s = 0; s < 4; s++) good[s] = 1'($urandom_range(0, 1));
    good[0] = 1'b0;
    run_case(4, 1'b0, "rand");
    rand_ready = 1'b0;
    for (int s = 0; s < 16; s++) good[s] = 1'b1;

    // Write-address accepted three cycles after write data.
    aw_delay = 3;
    run_case(1, 1'b0, "awdly");
    check("awdly_aw_after_w", 32'(aw_cyc - w_cyc), 32'd3);
    aw_delay = 0;

    // First sample never interrupts and must time out.
    mask[0] = 1'b0;
    run_case(2, 1'b0, "tmo");
    mask[0] = 1'b1;

    // Reset while streaming, then a fresh run from sample 0.
    clear_env();
    for (int a = 0; a < 2 * STR; a++) mem[a] = 16'($urandom);
    start_run(2);
    seen = 0;
    for (int n = 0; n < 100 && !seen; n++) begin
      @(negedge s_axi_aclk);
      seen = bus.axis_out_valid;
    end
    check("mrst_stream_seen", 32'(seen), 32'd1);
    #2 s_axi_aresetn = 1'b0;
    #1;
    check("mrst_tvalid", 32'(bus.axis_out_valid), 32'd0);
    check("mrst_busy",   32'(busy), 32'd0);
    check("mrst_rd_en",  32'(bus.mem_rd_en), 32'd0);
    repeat (2) @(negedge s_axi_aclk);
    check("mrst_right", 32'(right_cnt), 32'd0);
    @(posedge s_axi_aclk); #1;
    s_axi_aresetn = 1'b1;
    run_case(1, 1'b0, "after_rst");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
